// File: rtl/tile_grid_renderer.sv
// tile_grid_renderer: rasterises a GRID_N x GRID_N board of tiles through an
// external tile ROM and emits plot strobes for a VGA adapter.
// Optional feature macro: TILE_GRID_BORDER_EN (blanks local_x==0 / local_y==0
// pixels of every tile to draw grid lines).
module tile_grid_renderer #(
  parameter int GRID_N     = 4,
  parameter int TILE_PX    = 40,
  parameter int ORIGIN_X   = 80,
  parameter int ORIGIN_Y   = 40,
  parameter int VAL_W      = 4,
  parameter int ROM_LAT    = 1,
  parameter int PIX_DIV    = 2,
  parameter int CONTINUOUS = 0
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  input  logic [GRID_N*GRID_N*VAL_W-1:0]      board,
  output logic [VAL_W-1:0]                    tile_value,
  output logic [$clog2(TILE_PX*TILE_PX)-1:0]  tile_addr,
  input  logic [2:0]                          rom_colour,
  output logic [8:0]                          x,
  output logic [7:0]                          y,
  output logic [2:0]                          colour,
  output logic                                plot,
  output logic                                busy,
  output logic                                done
);

  localparam int AW = $clog2(TILE_PX*TILE_PX);
  localparam int LW = (TILE_PX > 1) ? $clog2(TILE_PX) : 1;
  localparam int GW = (GRID_N > 1) ? $clog2(GRID_N) : 1;
  localparam int NT = GRID_N*GRID_N;
  localparam int TW = (NT > 1) ? $clog2(NT) : 1;
  localparam int DW = 3;

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;
  state_t state, state_nx;

  logic [VAL_W-1:0] snap [NT];
  logic [LW-1:0]    lx, ly;
  logic [GW-1:0]    col, row;
  logic [AW-1:0]    ly_base;
  logic [8:0]       scan_x;
  logic [7:0]       scan_y;
  logic [DW-1:0]    div;
  logic [TW-1:0]    tidx;
  logic             issue, load_snap, last_pix, out_last;
  logic             lx_end, ly_end, col_end, row_end;

  // Stage i holds the pixel issued i+1 clocks ago; the last stage feeds the outputs.
  logic             p_vld  [0:ROM_LAT];
  logic             p_last [0:ROM_LAT];
  logic [8:0]       p_x    [0:ROM_LAT];
  logic [7:0]       p_y    [0:ROM_LAT];
`ifdef TILE_GRID_BORDER_EN
  logic             p_brd  [0:ROM_LAT];
`endif

  assign lx_end   = (lx  == LW'(TILE_PX-1));
  assign ly_end   = (ly  == LW'(TILE_PX-1));
  assign col_end  = (col == GW'(GRID_N-1));
  assign row_end  = (row == GW'(GRID_N-1));
  assign last_pix = lx_end && col_end && ly_end && row_end;
  assign tidx     = TW'(int'(row)*GRID_N + int'(col));
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic, issue strobe and snapshot request
  always_comb begin
    state_nx  = state;
    issue     = 1'b0;
    load_snap = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          load_snap = 1'b1;
          state_nx  = SCAN;
        end
      end
      SCAN: begin
        if (div == '0) begin
          issue = 1'b1;
          if (last_pix) state_nx = DRAIN;
        end
      end
      DRAIN: begin
        if (out_last) state_nx = DONE;
      end
      DONE: begin
        if (CONTINUOUS != 0) begin
          load_snap = 1'b1;
          state_nx  = SCAN;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Board snapshot, pixel pacing, wrapping raster counters and ROM address outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned k = 0; k < NT; k++) snap[k] <= '0;
      lx         <= '0;
      ly         <= '0;
      col        <= '0;
      row        <= '0;
      ly_base    <= '0;
      scan_x     <= 9'(ORIGIN_X);
      scan_y     <= 8'(ORIGIN_Y);
      div        <= '0;
      tile_value <= '0;
      tile_addr  <= '0;
    end else begin
      if (load_snap) begin
        for (int unsigned k = 0; k < NT; k++) snap[k] <= board[k*VAL_W +: VAL_W];
      end
      if (state == SCAN && div != DW'(PIX_DIV-1)) div <= div + DW'(1);
      else                                        div <= '0;
      if (issue) begin
        tile_value <= snap[tidx];
        tile_addr  <= ly_base + AW'(lx);
        // ly_base tracks local_y*TILE_PX incrementally so no multiplier is needed.
        if (lx_end) begin
          lx <= '0;
          if (col_end) begin
            col    <= '0;
            scan_x <= 9'(ORIGIN_X);
            if (ly_end) begin
              ly      <= '0;
              ly_base <= '0;
              if (row_end) begin
                row    <= '0;
                scan_y <= 8'(ORIGIN_Y);
              end else begin
                row    <= row + GW'(1);
                scan_y <= scan_y + 8'd1;
              end
            end else begin
              ly      <= ly + LW'(1);
              ly_base <= ly_base + AW'(TILE_PX);
              scan_y  <= scan_y + 8'd1;
            end
          end else begin
            col    <= col + GW'(1);
            scan_x <= scan_x + 9'd1;
          end
        end else begin
          lx     <= lx + LW'(1);
          scan_x <= scan_x + 9'd1;
        end
      end
    end
  end

  // Delay x/y/plot to meet the ROM data, and register the colour output
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i <= ROM_LAT; i++) begin
        p_vld[i]  <= 1'b0;
        p_last[i] <= 1'b0;
        p_x[i]    <= 9'(ORIGIN_X);
        p_y[i]    <= 8'(ORIGIN_Y);
`ifdef TILE_GRID_BORDER_EN
        p_brd[i]  <= 1'b0;
`endif
      end
      plot     <= 1'b0;
      out_last <= 1'b0;
      colour   <= '0;
      x        <= 9'(ORIGIN_X);
      y        <= 8'(ORIGIN_Y);
    end else begin
      p_vld[0]  <= issue;
      p_last[0] <= issue && last_pix;
      p_x[0]    <= scan_x;
      p_y[0]    <= scan_y;
`ifdef TILE_GRID_BORDER_EN
      p_brd[0]  <= (lx == '0) || (ly == '0);
`endif
      for (int unsigned i = 1; i <= ROM_LAT; i++) begin
        p_vld[i]  <= p_vld[i-1];
        p_last[i] <= p_last[i-1];
        p_x[i]    <= p_x[i-1];
        p_y[i]    <= p_y[i-1];
`ifdef TILE_GRID_BORDER_EN
        p_brd[i]  <= p_brd[i-1];
`endif
      end
      plot     <= p_vld[ROM_LAT];
      out_last <= p_last[ROM_LAT];
      x        <= p_x[ROM_LAT];
      y        <= p_y[ROM_LAT];
`ifdef TILE_GRID_BORDER_EN
      colour   <= p_brd[ROM_LAT] ? 3'b000 : {rom_colour[0], rom_colour[1], rom_colour[2]};
`else
      colour   <= {rom_colour[0], rom_colour[1], rom_colour[2]};
`endif
    end
  end

endmodule

// File: tb/tb_tile_grid_renderer.sv
// tb_tile_grid_renderer: randomized self-checking bench with a frame-level
// timing model and a pixel model computed from raster arithmetic.
module tb_tile_grid_renderer;

  localparam int GN  = 3;
  localparam int TP  = 6;
  localparam int OX  = 80;
  localparam int OY  = 40;
  localparam int VW  = 4;
  localparam int L   = 2;
  localparam int D   = 2;
  localparam int BW  = GN*GN*VW;
  localparam int AWB = $clog2(TP*TP);
  localparam int T   = GN*TP*GN*TP;
  localparam int DONE_C = L + 3 + (T-1)*D;

  logic           clk = 1'b0;
  logic           reset, start;
  logic [BW-1:0]  board;
  logic [VW-1:0]  tile_value;
  logic [AWB-1:0] tile_addr;
  logic [2:0]     rom_colour;
  logic [8:0]     x;
  logic [7:0]     y;
  logic [2:0]     colour;
  logic           plot, busy, done;

  int checks = 0;
  int errors = 0;

  tile_grid_renderer #(
    .GRID_N(GN), .TILE_PX(TP), .ORIGIN_X(OX), .ORIGIN_Y(OY), .VAL_W(VW),
    .ROM_LAT(L), .PIX_DIV(D), .CONTINUOUS(0)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .board(board),
    .tile_value(tile_value), .tile_addr(tile_addr), .rom_colour(rom_colour),
    .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Content of the external tile ROM, by tile value and address.
  function automatic int romf(input int v, input int a);
    return (v*5 + a + a/7) % 8;
  endfunction

  // External ROM with L cycles of read latency.
  logic [2:0] rp [0:L-1];
  always @(posedge clk) begin
    rp[0] <= 3'(romf(int'(tile_value), int'(tile_addr)));
    for (int i = 1; i < L; i++) rp[i] <= rp[i-1];
  end
  assign rom_colour = rp[L-1];

  // Expected pixel k of a frame rendered from snapshot sb.
  function automatic void exp_pix(input int k, input logic [BW-1:0] sb,
                                  output int ex, output int ey, output int etv,
                                  output int eaddr, output int ecol);
    int w, kx, ky, tc, tr, lxx, lyy, c;
    w   = GN*TP;
    kx  = k % w;
    ky  = k / w;
    tc  = kx / TP;
    tr  = ky / TP;
    lxx = kx % TP;
    lyy = ky % TP;
    ex  = OX + kx;
    ey  = OY + ky;
    etv = int'(sb >> ((tr*GN + tc)*VW)) & ((1 << VW) - 1);
    eaddr = lyy*TP + lxx;
    c = romf(etv, eaddr);
    ecol = ((c & 1) << 2) | (c & 2) | ((c >> 2) & 1);
`ifdef TILE_GRID_BORDER_EN
    if (lxx == 0 || lyy == 0) ecol = 0;
`endif
  endfunction

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, expv, $time);
    end
  endtask

  function automatic logic [BW-1:0] rnd();
    return BW'({$urandom(), $urandom()});
  endfunction

  // Model state
  bit            mdl_busy = 0;
  int            c = 0;
  int            fplots = 0;
  int            frames = 0;
  int            plot_tot = 0;
  logic          rst_p = 1'b1;
  logic          start_p = 1'b0;
  logic [BW-1:0] board_p = '0;
  logic [BW-1:0] snapb = '0;
  bit            lit_b = 0;
  int            hv [0:7];
  int            ha [0:7];

  // Compare process: outputs at each negedge reflect the inputs seen at the previous one.
  always @(negedge clk) begin
    int k, ex, ey, etv, ea, ec;
    bit ep;
    if (rst_p) begin
      mdl_busy = 0;
      fplots   = 0;
      chk("rst_plot", int'(plot), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_x", int'(x), OX);
      chk("rst_y", int'(y), OY);
      chk("rst_colour", int'(colour), 0);
      chk("rst_tile_value", int'(tile_value), 0);
      chk("rst_tile_addr", int'(tile_addr), 0);
    end else begin
      if (mdl_busy) begin
        if (c == DONE_C) mdl_busy = 0;
        else c++;
      end else if (start_p) begin
        mdl_busy = 1;
        c        = 0;
        snapb    = board_p;
        fplots   = 0;
      end
      ep = mdl_busy && c >= L+2 && ((c-L-2) % D == 0) && ((c-L-2)/D < T);
      chk("plot", int'(plot), int'(ep));
      chk("busy", int'(busy), int'(mdl_busy));
      chk("done", int'(done), int'(mdl_busy && c == DONE_C));
      if (plot && ep) begin
        k = (c-L-2)/D;
        exp_pix(k, snapb, ex, ey, etv, ea, ec);
        chk("x", int'(x), ex);
        chk("y", int'(y), ey);
        chk("colour", int'(colour), ec);
        chk("tile_value", hv[L], etv);
        chk("tile_addr", ha[L], ea);
        if (k == 0) begin
          chk("first_x", int'(x), 80);
          chk("first_y", int'(y), 40);
        end
        if (k == T-1) begin
          chk("last_x", int'(x), 97);
          chk("last_y", int'(y), 57);
        end
        if (lit_b && x == 9'd92 && y == 8'd46) begin
          chk("lit_tval_92_46", hv[L], 11);
          chk("lit_addr_92_46", ha[L], 0);
        end
        if (lit_b && x == 9'd97 && y == 8'd51) begin
          chk("lit_tval_97_51", hv[L], 11);
          chk("lit_addr_97_51", ha[L], 35);
        end
        if (lit_b && x == 9'd91 && y == 8'd46) chk("lit_tval_91_46", hv[L], 0);
        fplots++;
        plot_tot++;
      end
      if (mdl_busy && c == DONE_C) begin
        chk("frame_plots", fplots, 324);
        frames++;
      end
    end
    for (int j = 7; j > 0; j--) begin
      hv[j] = hv[j-1];
      ha[j] = ha[j-1];
    end
    hv[0]   = int'(tile_value);
    ha[0]   = int'(tile_addr);
    rst_p   = reset;
    start_p = start;
    board_p = board;
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_frame(input int lim, input bit scramble);
    int f0, n;
    f0 = frames;
    n  = 0;
    while (frames == f0 && n < lim) begin
      @(posedge clk); #1;
      if (scramble) board = rnd();
      n++;
    end
    chk("frame_done_seen", int'(frames != f0), 1);
  endtask

  initial begin
    int ex, ey, etv, ea, ec, p0, n;
    logic [BW-1:0] bb;
    reset = 1'b1;
    start = 1'b0;
    board = '0;

    // Pin the model with hand-computed values.
    bb = '0;
    bb[(1*GN+2)*VW +: VW] = 4'hB;
    exp_pix(0, '0, ex, ey, etv, ea, ec);
    chk("mdl_p0_x", ex, 80); chk("mdl_p0_y", ey, 40); chk("mdl_p0_addr", ea, 0);
    exp_pix(323, '0, ex, ey, etv, ea, ec);
    chk("mdl_last_x", ex, 97); chk("mdl_last_y", ey, 57); chk("mdl_last_addr", ea, 35);
    exp_pix(120, bb, ex, ey, etv, ea, ec);
    chk("mdl_b_x", ex, 92); chk("mdl_b_y", ey, 46); chk("mdl_b_tv", etv, 11); chk("mdl_b_addr", ea, 0);
    exp_pix(215, bb, ex, ey, etv, ea, ec);
    chk("mdl_b2_tv", etv, 11); chk("mdl_b2_addr", ea, 35);
    exp_pix(119, bb, ex, ey, etv, ea, ec);
    chk("mdl_b3_tv", etv, 0);
    exp_pix(20, '0, ex, ey, etv, ea, ec);
    chk("mdl_col_20", ec, 4);

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // All-zero board
    pulse_start();
    wait_frame(1000, 0);

    // Single 4'hB tile at (1,2)
    board = bb;
    lit_b = 1;
    pulse_start();
    wait_frame(1000, 0);
    lit_b = 0;

    // Board churn and start pulses during the frame must not disturb it
    board = rnd();
    pulse_start();
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      board = rnd();
      start = ($urandom_range(0, 3) == 0);
    end
    start = 1'b0;
    wait_frame(1000, 1);
    repeat (30) @(posedge clk);

    // Reset around pixel 100 with start asserted in the same clock
    board = rnd();
    pulse_start();
    p0 = plot_tot;
    n  = 0;
    while (plot_tot - p0 < 100 && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("reached_px100", int'(plot_tot - p0 >= 100), 1);
    reset = 1'b1; start = 1'b1;
    @(posedge clk); #1 reset = 1'b0; start = 1'b0;
    repeat (8) @(posedge clk);
    #1 board = rnd();
    pulse_start();
    wait_frame(1000, 1);

    // Reset and start together while idle: reset wins
    @(posedge clk); #1 reset = 1'b1; start = 1'b1;
    @(posedge clk); #1 reset = 1'b0; start = 1'b0;
    repeat (5) @(posedge clk);

    // Back-to-back frames with start held high and a changing board
    for (int f = 0; f < 3; f++) begin
      #1 board = rnd();
      start = 1'b1;
      wait_frame(1000, 1);
    end
    start = 1'b0;
    repeat (20) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tile_grid_renderer.md
TILE_GRID_RENDERER -- requirements
Module: tile_grid_renderer

Interface
REQ-001 The block SHALL have the following parameters (name, default, meaning):
- GRID_N, 4: tiles per row and per column.
- TILE_PX, 40: tile edge length in pixels.
- ORIGIN_X, 80: screen x of the grid's left edge.
- ORIGIN_Y, 40: screen y of the grid's top edge.
- VAL_W, 4: bits per tile value.
- ROM_LAT, 1: tile ROM read latency in cycles, 1..3.
- PIX_DIV, 2: clocks per pixel step, 1..4.
- CONTINUOUS, 0: when 1, a new frame restarts automatically after done.
REQ-002 The block SHALL have the following ports (name, direction, width, meaning):
- clk, in, 1: single clock.
- reset, in, 1: synchronous, active-high.
- start, in, 1: request one frame render.
- board, in, GRID_N*GRID_N*VAL_W: tile (r,c) is at bits [(r*GRID_N+c)*VAL_W +: VAL_W]; row 0 is the top row.
- tile_value, out, VAL_W: value of the tile being addressed; selects the external ROM.
- tile_addr, out, clog2(TILE_PX*TILE_PX): address within the tile, equal to local_y*TILE_PX+local_x.
- rom_colour, in, 3: ROM pixel, {B,G,R} order, valid ROM_LAT cycles after tile_addr.
- x, out, 9: screen x aligned with colour.
- y, out, 8: screen y aligned with colour.
- colour, out, 3: pixel in {R,G,B} order, driven to the VGA adapter.
- plot, out, 1: write strobe for x/y/colour.
- busy, out, 1: high while a frame is in flight.
- done, out, 1: one-cycle pulse after the last pixel has been plotted.
REQ-003 The clock SHALL be one clock; reset SHALL be synchronous and active-high.

Function
REQ-004 The FSM SHALL have four states: IDLE, SCAN, DRAIN, DONE.
REQ-005 In IDLE, start=1 SHALL capture board into an internal snapshot and move to SCAN; later changes to board SHALL NOT affect the frame in progress.
REQ-006 SCAN SHALL issue one pixel every PIX_DIV clocks, raster order, from (ORIGIN_X, ORIGIN_Y) to (ORIGIN_X+GRID_N*TILE_PX-1, ORIGIN_Y+GRID_N*TILE_PX-1).
REQ-007 Tile row/column and local x/y SHALL be kept as wrapping counters; division and modulo SHALL NOT be used.
- local_x wraps at TILE_PX-1 and increments the tile column.
- The tile column wraps at GRID_N-1 and advances local_y.
REQ-008 tile_value and tile_addr SHALL be registered outputs updated on each issue cycle.
REQ-009 x, y and plot SHALL be delayed so that colour/x/y/plot appear exactly ROM_LAT+1 clocks after the matching tile_addr issue.
REQ-010 plot SHALL be high for exactly one clock per pixel, and SHALL be low outside frames.
REQ-011 colour SHALL equal {rom_colour[0], rom_colour[1], rom_colour[2]} (R and B swapped).
REQ-012 After the last pixel is issued, the FSM SHALL enter DRAIN until the final plot has been asserted.
REQ-013 DONE SHALL last one clock, with done=1, then return to IDLE; when CONTINUOUS=1 it SHALL instead re-snapshot board and enter SCAN.
REQ-014 busy SHALL be 1 in SCAN, DRAIN and DONE, and 0 in IDLE.
REQ-015 start SHALL be ignored while busy=1; it is not queued.
REQ-016 start and reset asserted in the same clock SHALL resolve with reset winning.

Reset
REQ-017 On reset=1 the block SHALL take these values on the next clock:
- FSM in IDLE.
- All counters and the delay pipeline cleared.
- plot=0, busy=0, done=0, colour=0, x=ORIGIN_X, y=ORIGIN_Y, tile_value=0, tile_addr=0.
REQ-018 Reset mid-frame SHALL abort the frame immediately; no further plot pulses SHALL occur until the next start.

Configuration
REQ-019 With macro TILE_GRID_BORDER_EN defined, pixels with local_x=0 or local_y=0 SHALL output colour 3'b000 (grid line) regardless of rom_colour, with the same latency and plot timing.
REQ-020 Without TILE_GRID_BORDER_EN, all pixels SHALL come from rom_colour per REQ-011.

Verification
REQ-021 Defaults, start pulse, all-zero board:
- exactly 25600 plot pulses, one every 2 clocks.
- first at (80,40), last at (239,199).
- done exactly 1 clock after the last plot; busy low the clock after done.
REQ-022 Board with tile(1,2)=4'hB, others 0:
- tile_value=4'hB exactly for x 160..199, y 80..119.
- tile_addr=0 at (160,80) and 1599 at (199,119).
REQ-023 ROM_LAT=3, PIX_DIV=1, rom_colour driven from tile_addr via a 3-stage model returning 3'b001:
- colour=3'b100 on every plot.
- plots arrive 4 clocks after the addresses.
REQ-024 Change board mid-frame and assert start while busy:
- the frame output matches the original snapshot.
- no second frame follows.
REQ-025 Assert reset at pixel 1000:
- plot=0 from the next clock, busy=0, x=80, y=40.
- a subsequent start renders the full 25600 pixels.
REQ-026 With TILE_GRID_BORDER_EN defined and rom_colour=3'b111: colour=3'b000 at (80,40), (120,41) and (81,80); colour=3'b111 at (81,41).
